// File: rtl/breakout_sound_pkg.sv
// Shared definitions for the breakout sound scheduler: event IDs, state
// encoding, the per-event tone/duration tables and width defaults.
package breakout_sound_pkg;

  localparam int HALF_W_DEF = 16;
  localparam int DUR_W_DEF  = 5;

  localparam logic [1:0] ID_WALL   = 2'd0;
  localparam logic [1:0] ID_PADDLE = 2'd1;
  localparam logic [1:0] ID_BRICK  = 2'd2;
  localparam logic [1:0] ID_LIFE   = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_PLAY
  } state_e;

  // Indexed by event ID; element 0 is the rightmost entry.
  localparam logic [3:0][31:0] HALF_TABLE = {32'd50000, 32'd8333, 32'd25000, 32'd12500};
  localparam logic [3:0][31:0] DUR_TABLE  = {32'd30, 32'd4, 32'd3, 32'd2};

  // Fixed priority: the highest-numbered pending event wins.
  function automatic logic [1:0] highest_id(input logic [3:0] pend);
    logic [1:0] id;
    id = ID_WALL;
    if (pend[ID_PADDLE]) id = ID_PADDLE;
    if (pend[ID_BRICK])  id = ID_BRICK;
    if (pend[ID_LIFE])   id = ID_LIFE;
    return id;
  endfunction

endpackage

// File: rtl/sound_tone_gen.sv
// Half-period divider producing the square-wave tone level. A load restarts
// the phase high; while running the level toggles every half_i clocks.
module sound_tone_gen #(
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              load_i,
  input  logic              run_i,
  input  logic              clear_i,
  input  logic [HALF_W-1:0] half_i,
  output logic              level_o
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0] reload;
  logic              level_q, level_d;

  assign reload = half_i - HALF_W'(1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    level_d = level_q;
    if (clear_i) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (load_i) begin
      cnt_d   = reload;
      level_d = 1'b1;
    end else if (run_i) begin
      if (cnt_q == '0) begin
        cnt_d   = reload;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q - HALF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (en_i) begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/sound_scheduler.sv
// Sound effect scheduler: latches event requests, arbitrates by fixed
// priority, times each effect in video frames and gates the tone output.
module sound_scheduler
  import breakout_sound_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vblank,
  input  logic       mute,
  input  logic [3:0] req,
  output logic       sound_out,
  output logic       busy,
  output logic [1:0] active_id
);

  state_e           state_q, state_d;
  logic [3:0]       pending_q, pending_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [1:0]       active_q, active_d;
  logic             vblank_q;

  logic             tick;
  logic             any_pending;
  logic [1:0]       top_id;
  logic             grant;
  logic             finish;
  logic [1:0]       tone_id;
  logic [HALF_W-1:0] half_sel;
  logic             tone_level;

  assign tick        = vblank & ~vblank_q;
  assign any_pending = |pending_q;
  assign top_id      = highest_id(pending_q);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dur_d     = dur_q;
    active_d  = active_q;
    grant     = 1'b0;
    finish    = 1'b0;

    unique case (state_q)
      ST_IDLE: grant = any_pending;
      ST_PLAY: begin
        // End of effect wins over preemption; pending work waits one idle cycle.
        if (tick && dur_q == DUR_W'(1)) begin
          finish = 1'b1;
        end else if (any_pending && top_id >= active_q) begin
          grant = 1'b1;
        end else if (tick) begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d   = ST_PLAY;
      active_d  = top_id;
      dur_d     = DUR_W'(DUR_TABLE[top_id]);
      pending_d = pending_q & ~(4'b0001 << top_id);
    end
    if (finish) begin
      state_d  = ST_IDLE;
      active_d = 2'd0;
      dur_d    = '0;
    end

    // A request arriving on a grant edge is kept, even for the granted ID.
    pending_d = pending_d | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      dur_q     <= '0;
      active_q  <= 2'd0;
      vblank_q  <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dur_q     <= dur_d;
      active_q  <= active_d;
      vblank_q  <= vblank;
    end
  end

  assign tone_id  = grant ? top_id : active_q;
  assign half_sel = HALF_W'(HALF_TABLE[tone_id]);

  sound_tone_gen #(
    .HALF_W(HALF_W)
  ) u_tone (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .load_i  (grant),
    .run_i   (state_q == ST_PLAY),
    .clear_i (finish),
    .half_i  (half_sel),
    .level_o (tone_level)
  );

  assign busy      = (state_q == ST_PLAY);
  assign active_id = active_q;
  assign sound_out = tone_level & busy & ~mute & en;

endmodule

// File: tb/tb_sound_scheduler.sv
// Self-checking bench for sound_scheduler: a vector table checked through a
// scoreboard queue, then directed multi-cycle scenarios.
module tb_sound_scheduler;

  logic       clk = 1'b0;
  logic       rst, en, vblank, mute;
  logic [3:0] req;
  logic       sound_out, busy;
  logic [1:0] active_id;

  int n_checks = 0;
  int n_fail   = 0;
  int n, bad;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       vblank;
    logic       mute;
    logic [3:0] req;
    logic       exp_busy;
    logic [1:0] exp_id;
    logic       exp_snd;
  } vec_t;

  typedef struct {
    logic       busy;
    logic [1:0] id;
    logic       snd;
    int         row;
  } exp_t;

  vec_t vecs [18];
  exp_t sb[$];
  exp_t e;

  sound_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .vblank    (vblank),
    .mute      (mute),
    .req       (req),
    .sound_out (sound_out),
    .busy      (busy),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int cnt);
    repeat (cnt) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; vblank = 1'b0; mute = 1'b0; req = 4'b0000;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Request is sampled on the edge inside this task.
  task automatic pulse_req(input logic [3:0] bits);
    req = bits;
    step();
    req = 4'b0000;
  endtask

  // One vblank rising edge: the frame tick lands on the first edge.
  task automatic frame();
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
  endtask

  task automatic count_level(input logic lvl, input int limit, output int cnt);
    cnt = 0;
    while (sound_out == lvl && cnt < limit) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    // rst en vb mute req  | busy id snd
    vecs[0]  = 12'b0_1_0_0_0000_0_00_0;
    vecs[1]  = 12'b0_1_0_0_0010_0_00_0;  // pending only
    vecs[2]  = 12'b0_1_0_0_0000_1_01_1;  // grant ID1
    vecs[3]  = 12'b0_1_0_1_0000_1_01_0;  // muted
    vecs[4]  = 12'b0_1_0_0_0000_1_01_1;
    vecs[5]  = 12'b0_0_1_0_0000_1_01_0;  // disabled, vblank ignored
    vecs[6]  = 12'b0_1_1_0_0000_1_01_1;  // tick: 3 -> 2
    vecs[7]  = 12'b0_1_1_0_0000_1_01_1;
    vecs[8]  = 12'b0_1_0_0_0001_1_01_1;  // lower ID held
    vecs[9]  = 12'b0_1_0_0_0000_1_01_1;
    vecs[10] = 12'b0_1_1_0_0000_1_01_1;  // tick: 2 -> 1
    vecs[11] = 12'b0_1_0_0_0000_1_01_1;
    vecs[12] = 12'b0_1_1_0_0000_0_00_0;  // tick ends play
    vecs[13] = 12'b0_1_1_0_0000_1_00_1;  // held ID0 granted
    vecs[14] = 12'b0_1_0_0_1000_1_00_1;
    vecs[15] = 12'b0_1_0_0_0000_1_11_1;  // ID3 preempts
    vecs[16] = 12'b1_1_0_0_0000_0_00_0;  // reset mid-play
    vecs[17] = 12'b0_1_0_0_0000_0_00_0;

    rst = 1'b1; en = 1'b1; vblank = 1'b0; mute = 1'b0; req = 4'b0000;
    step();
    check("reset busy", busy, 0);
    check("reset id", active_id, 0);
    check("reset sound", sound_out, 0);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      rst    = vecs[i].rst;
      en     = vecs[i].en;
      vblank = vecs[i].vblank;
      mute   = vecs[i].mute;
      req    = vecs[i].req;
      sb.push_back('{busy: vecs[i].exp_busy, id: vecs[i].exp_id, snd: vecs[i].exp_snd, row: i});
      step();
      e = sb.pop_front();
      check($sformatf("vec%0d busy", e.row), busy, e.busy);
      check($sformatf("vec%0d id", e.row), active_id, e.id);
      check($sformatf("vec%0d sound", e.row), sound_out, e.snd);
    end

    // Single ID1 event: one-cycle latency, 25000-clock half period, 3 frames.
    do_reset();
    pulse_req(4'b0010);
    check("s1 busy on req edge", busy, 0);
    step();
    check("s1 busy after grant", busy, 1);
    check("s1 id", active_id, 1);
    check("s1 sound high", sound_out, 1);
    count_level(1'b1, 30000, n);
    check("s1 high time", n, 25000);
    frame();
    check("s1 busy frame1", busy, 1);
    frame();
    check("s1 busy frame2", busy, 1);
    frame();
    check("s1 busy frame3", busy, 0);
    check("s1 sound frame3", sound_out, 0);

    // ID0 and ID2 together: ID2 for 4 frames, one idle cycle, then ID0.
    do_reset();
    pulse_req(4'b0101);
    step();
    check("s2 id2 granted", active_id, 2);
    check("s2 busy", busy, 1);
    count_level(1'b1, 20000, n);
    check("s2 id2 high time", n, 8333);
    frame();
    frame();
    frame();
    check("s2 busy frame3", busy, 1);
    check("s2 id frame3", active_id, 2);
    vblank = 1'b1;
    step();
    check("s2 idle gap busy", busy, 0);
    check("s2 idle gap id", active_id, 0);
    vblank = 1'b0;
    step();
    check("s2 id0 busy", busy, 1);
    check("s2 id0 id", active_id, 0);
    check("s2 id0 sound", sound_out, 1);
    count_level(1'b1, 20000, n);
    check("s2 id0 high time", n, 12500);
    count_level(1'b0, 20000, n);
    check("s2 id0 low time", n, 12500);
    frame();
    check("s2 id0 busy frame1", busy, 1);
    frame();
    check("s2 id0 busy frame2", busy, 0);

    // ID3 preempts ID1 and plays 30 frames; ID1 is never resumed.
    do_reset();
    pulse_req(4'b0010);
    step();
    steps(20);
    check("s3 id1 playing", active_id, 1);
    pulse_req(4'b1000);
    check("s3 id before preempt", active_id, 1);
    step();
    check("s3 id3 granted", active_id, 3);
    check("s3 sound high", sound_out, 1);
    for (int f = 1; f < 30; f++) begin
      frame();
      check($sformatf("s3 busy frame%0d", f), busy, 1);
    end
    check("s3 id still 3", active_id, 3);
    frame();
    check("s3 busy frame30", busy, 0);
    steps(10);
    check("s3 no resume busy", busy, 0);
    check("s3 no resume id", active_id, 0);

    // ID2 re-requested after 2 frames: phase and duration restart.
    do_reset();
    pulse_req(4'b0100);
    step();
    check("s4 id2 granted", active_id, 2);
    frame();
    frame();
    count_level(1'b1, 20000, n);
    check("s4 tone in low half", sound_out, 0);
    pulse_req(4'b0100);
    step();
    check("s4 phase restart", sound_out, 1);
    check("s4 id", active_id, 2);
    for (int f = 1; f < 4; f++) begin
      frame();
      check($sformatf("s4 busy frame%0d", f), busy, 1);
    end
    frame();
    check("s4 busy frame4", busy, 0);

    // en low for 1000 cycles mid-play with vblank toggling and a req.
    do_reset();
    pulse_req(4'b0010);
    step();
    frame();
    steps(5);
    check("s5 sound before pause", sound_out, 1);
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 3 == 0) vblank = ~vblank;
      req = (i == 500) ? 4'b1000 : 4'b0000;
      step();
      if (sound_out !== 1'b0 || busy !== 1'b1 || active_id !== 2'd1) bad++;
    end
    check("s5 frozen cycles bad", bad, 0);
    req    = 4'b0000;
    vblank = 1'b0;
    en     = 1'b1;
    step();
    check("s5 tone resumes", sound_out, 1);
    check("s5 id after resume", active_id, 1);
    frame();
    check("s5 busy frame2", busy, 1);
    frame();
    check("s5 busy frame3", busy, 0);

    // Reset mid-play with a lower event pending: nothing is granted later.
    do_reset();
    pulse_req(4'b0010);
    step();
    pulse_req(4'b0001);
    check("s6 id1 playing", active_id, 1);
    check("s6 busy", busy, 1);
    rst = 1'b1;
    step();
    check("s6 reset busy", busy, 0);
    check("s6 reset id", active_id, 0);
    check("s6 reset sound", sound_out, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      frame();
      steps(2);
      if (busy !== 1'b0) bad++;
    end
    check("s6 no later grant", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 The block SHALL have parameter HALF_W, default 16, setting the width of the tone half-period counter.
REQ-002 The block SHALL have parameter DUR_W, default 5, setting the width of the duration counter (frames).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port en, input, 1: design enable; low freezes all state.
REQ-006 Port vblank, input, 1: level from the VGA timing; its rising edge is the frame tick.
REQ-007 Port mute, input, 1: forces sound_out low without affecting scheduling.
REQ-008 Port req, input, 4: one-cycle event pulses: bit0 wall hit, bit1 paddle hit, bit2 brick hit, bit3 life lost.
REQ-009 Port sound_out, output, 1: square-wave audio.
REQ-010 Port busy, output, 1: high while in PLAY.
REQ-011 Port active_id, output, 2: event ID currently playing; 0 when idle.

Function
REQ-012 Each req bit SHALL set the matching pending bit on the edge it is sampled high; a pending bit clears on the edge its event is granted.
REQ-013 Priority SHALL be fixed: ID3 > ID2 > ID1 > ID0.
REQ-014 States SHALL be IDLE and PLAY only.
REQ-015 IDLE -> PLAY on the first edge where pending (after REQ-012 update of the previous edge) is nonzero; grant the highest pending ID.
   - Minimum latency: req high at edge N, grant at edge N+1.
REQ-016 On grant the block SHALL:
   - load the half-period counter with HALF[id]-1;
   - load the duration counter with DUR[id];
   - drive the tone level high;
   - set active_id = id.
REQ-017 In PLAY the half-period counter SHALL decrement each enabled cycle; at 0 it toggles the tone level and reloads HALF[id]-1, giving a period of exactly 2*HALF[id] clocks.
REQ-018 The frame tick SHALL be vblank high with a registered vblank_d low, one cycle per rising edge.
   - In PLAY each tick decrements the duration counter.
   - A tick while the counter equals 1 returns to IDLE with the tone level low.
REQ-019 Preemption: in PLAY, a pending ID strictly higher than active_id SHALL be granted on the next edge per REQ-016; the preempted event is discarded.
REQ-020 A pending ID equal to active_id SHALL restart the duration and phase per REQ-016 and clear its pending bit.
   - Lower pending IDs are held until IDLE.
REQ-021 If a frame tick that ends PLAY coincides with a nonzero pending, the block SHALL enter IDLE for one cycle, then grant per REQ-015.
REQ-022 sound_out SHALL equal tone level AND busy AND NOT mute.
REQ-023 When en is low, all registers SHALL hold, including vblank_d and pending; req and vblank edges SHALL be ignored; sound_out SHALL be 0.
REQ-024 Constants:
   - HALF = {12500, 25000, 8333, 50000} for IDs 0..3;
   - DUR = {2, 3, 4, 30} frames;
   - all SHALL fit HALF_W and DUR_W without truncation.

Reset
REQ-025 On rst high at an edge the block SHALL set:
   - state IDLE; pending 0; counters 0; tone level 0; vblank_d 0;
   - outputs sound_out 0, busy 0, active_id 0.
REQ-026 rst SHALL take precedence over en and req.
   - Reset mid-PLAY SHALL silence the output on the same edge.
   - Pending events SHALL be lost.

Structure
REQ-027 Package breakout_sound_pkg SHALL hold:
   - event ID constants;
   - the state enum typedef;
   - the HALF and DUR tables;
   - HALF_W and DUR_W defaults.
REQ-028 One sub-module, sound_tone_gen, SHALL implement the half-period divider and tone level (load, half-period value, enable in; level out).
   - Arbitration, pending and duration logic stay in sound_scheduler.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
   - Single req[1] pulse at edge N: busy=1 and active_id=1 at N+1; sound_out period 50000 clocks. After 3 vblank rising edges: busy=0 and sound_out=0.
   - req[0] and req[2] in the same cycle: ID2 plays for 4 frames, then 1 idle cycle, then ID0 plays for 2 frames with period 25000.
   - ID1 playing, req[3] pulse: next edge active_id=3 and sound_out high. ID1 is never resumed; busy stays high 30 frames.
   - ID2 playing after 2 frames, req[2] again: duration reloads to 4 and phase restarts. Busy lasts 4 further frames.
   - en low for 1000 cycles mid-PLAY with vblank toggling: sound_out=0 and counters frozen. On en high, tone resumes with unchanged remaining duration.
   - rst high for one edge mid-PLAY with req[0] pending: all outputs 0 next cycle and no later grant.
